// File: rtl/alarm_pkg.sv
// Shared state encoding, zone/pin indices and helpers for the alarm zone controller.
// Pure declarations; no logic, no latency, no flow control.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } alarm_state_e;

  localparam int NUM_ZONES   = 3;
  localparam int ZONE_DOOR   = 0;
  localparam int ZONE_WINDOW = 1;
  localparam int ZONE_MOTION = 2;

  typedef logic [NUM_ZONES-1:0] zone_t;

  // Raw pin ordering inside the conditioned input vector.
  localparam int NUM_PINS   = 5;
  localparam int PIN_ARM    = 0;
  localparam int PIN_DOOR   = 1;
  localparam int PIN_WINDOW = 2;
  localparam int PIN_MOTION = 3;
  localparam int PIN_RESET  = 4;

  function automatic logic [23:0] max_delay(input logic [23:0] a, input logic [23:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stable-count debounce for one raw pin.
// Pin-to-output latency 2 + DEBOUNCE_CYCLES; no backpressure, ena low freezes every flop.
module input_debouncer
  import alarm_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic pin_in,
  output logic db_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 16'd1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised pin disagrees with the
  // debounced value, so any return to agreement restarts the stability window.
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (ena) begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_out = db_q;

endmodule

// File: rtl/alarm_zone_controller.sv
// Conditions alarm pins and runs the exit/entry-delay arming FSM with registered status flags.
// Flags change 1 cycle after a debounced input change; no backpressure, ena low holds all state.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] EXIT_DELAY      = 24'd250000,
  parameter logic [23:0] ENTRY_DELAY     = 24'd250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       arm_in,
  input  logic       door_in,
  input  logic       window_in,
  input  logic       motion_in,
  input  logic       reset_in,
  output logic       armed,
  output logic       exit_pending,
  output logic       entry_pending,
  output logic       alarm_active,
  output logic [2:0] zone_latched
);

  localparam logic [23:0] MAX_DELAY = max_delay(EXIT_DELAY, ENTRY_DELAY);
  localparam int CW = $clog2({1'b0, MAX_DELAY} + 25'd1);
  localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_DELAY - 24'd1);
  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 24'd1);

  logic [NUM_PINS-1:0] raw;
  logic [NUM_PINS-1:0] db;

  assign raw[PIN_ARM]    = arm_in;
  assign raw[PIN_DOOR]   = door_in;
  assign raw[PIN_WINDOW] = window_in;
  assign raw[PIN_MOTION] = motion_in;
  assign raw[PIN_RESET]  = reset_in;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_cond
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .pin_in(raw[i]),
      .db_out(db[i])
    );
  end

  zone_t sens;
  logic  instant_trip;
  logic  reset_req;

  assign sens[ZONE_DOOR]   = db[PIN_DOOR];
  assign sens[ZONE_WINDOW] = db[PIN_WINDOW];
  assign sens[ZONE_MOTION] = db[PIN_MOTION];
  assign instant_trip      = db[PIN_WINDOW] | db[PIN_MOTION];
  assign reset_req         = db[PIN_RESET];

  alarm_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  zone_t         zone_q, zone_d;
  logic          armed_q, armed_d;
  logic          exit_pending_q, exit_pending_d;
  logic          entry_pending_q, entry_pending_d;
  logic          alarm_active_q, alarm_active_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zone_d  = zone_q;
    if (!db[PIN_ARM]) begin
      state_d = ST_DISARMED;
      cnt_d   = '0;
      zone_d  = '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          state_d = ST_EXIT_DELAY;
          cnt_d   = EXIT_LOAD;
        end
        ST_EXIT_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_ARMED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_ARMED: begin
          // A held manual reset suppresses trips so a clear cannot re-trip instantly.
          if (!reset_req) begin
            if (instant_trip) begin
              state_d = ST_ALARM;
              zone_d  = sens;
            end else if (sens[ZONE_DOOR]) begin
              state_d = ST_ENTRY_DELAY;
              cnt_d   = ENTRY_LOAD;
              zone_d  = sens;
            end
          end
        end
        ST_ENTRY_DELAY: begin
          if (reset_req) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            zone_d  = '0;
          end else begin
            zone_d = zone_q | sens;
            if (instant_trip || (cnt_q == '0)) begin
              state_d = ST_ALARM;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_ALARM: begin
          if (reset_req) begin
            state_d = ST_ARMED;
            zone_d  = '0;
          end else begin
            zone_d = zone_q | sens;
          end
        end
        default: begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
          zone_d  = '0;
        end
      endcase
    end
  end

  // Flags are decoded from the next state so they are registered alongside it.
  always_comb begin
    armed_d         = state_d inside {ST_ARMED, ST_ENTRY_DELAY, ST_ALARM};
    exit_pending_d  = (state_d == ST_EXIT_DELAY);
    entry_pending_d = (state_d == ST_ENTRY_DELAY);
    alarm_active_d  = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_DISARMED;
      cnt_q           <= '0;
      zone_q          <= '0;
      armed_q         <= 1'b0;
      exit_pending_q  <= 1'b0;
      entry_pending_q <= 1'b0;
      alarm_active_q  <= 1'b0;
    end else if (ena) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      zone_q          <= zone_d;
      armed_q         <= armed_d;
      exit_pending_q  <= exit_pending_d;
      entry_pending_q <= entry_pending_d;
      alarm_active_q  <= alarm_active_d;
    end
  end

  assign armed         = armed_q;
  assign exit_pending  = exit_pending_q;
  assign entry_pending = entry_pending_q;
  assign alarm_active  = alarm_active_q;
  assign zone_latched  = zone_q;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Directed scenarios plus randomized pin activity, checked every cycle against a behavioural model.
module tb_alarm_zone_controller;

  localparam int DB_N  = 4;
  localparam int EXT_N = 16;
  localparam int ENT_N = 32;

  localparam int M_DIS   = 0;
  localparam int M_EXIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       arm_in = 1'b0, door_in = 1'b0, window_in = 1'b0, motion_in = 1'b0, reset_in = 1'b0;
  logic       armed, exit_pending, entry_pending, alarm_active;
  logic [2:0] zone_latched;

  alarm_zone_controller #(
    .DEBOUNCE_CYCLES(16'd4),
    .EXIT_DELAY     (24'd16),
    .ENTRY_DELAY    (24'd32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .arm_in       (arm_in),
    .door_in      (door_in),
    .window_in    (window_in),
    .motion_in    (motion_in),
    .reset_in     (reset_in),
    .armed        (armed),
    .exit_pending (exit_pending),
    .entry_pending(entry_pending),
    .alarm_active (alarm_active),
    .zone_latched (zone_latched)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_mode;
  int         m_left;
  logic [2:0] m_zone;
  logic [4:0] m_db;        // {reset, motion, window, door, arm}
  logic [4:0] pin_hist[$];
  logic [4:0] s_hist[$];

  function automatic logic [4:0] cur_pins();
    return {reset_in, motion_in, window_in, door_in, arm_in};
  endfunction

  task automatic model_reset();
    m_mode = M_DIS;
    m_left = 0;
    m_zone = 3'b000;
    m_db   = 5'b0;
    pin_hist.delete();
    s_hist.delete();
  endtask

  task automatic model_edge();
    logic [4:0] s_now;
    logic [4:0] new_db;
    logic [2:0] sens;
    logic       inst;
    logic       stable;
    if (!rst_n || !ena) return;
    sens = {m_db[3], m_db[2], m_db[1]};
    inst = m_db[2] | m_db[3];
    if (!m_db[0]) begin
      m_mode = M_DIS;
      m_zone = 3'b000;
    end else begin
      case (m_mode)
        M_DIS: begin m_mode = M_EXIT; m_left = EXT_N; end
        M_EXIT: begin
          m_left--;
          if (m_left == 0) m_mode = M_ARMED;
        end
        M_ARMED: if (!m_db[4]) begin
          if (inst) begin m_mode = M_ALARM; m_zone = sens; end
          else if (m_db[1]) begin m_mode = M_ENTRY; m_left = ENT_N; m_zone = sens; end
        end
        M_ENTRY: begin
          if (m_db[4]) begin m_mode = M_ARMED; m_zone = 3'b000; end
          else begin
            m_zone = m_zone | sens;
            m_left--;
            if (inst || m_left == 0) m_mode = M_ALARM;
          end
        end
        default: begin
          if (m_db[4]) begin m_mode = M_ARMED; m_zone = 3'b000; end
          else m_zone = m_zone | sens;
        end
      endcase
    end
    // A debounced bit flips once the pin, seen two edges late, has sat at the
    // opposite level for DB_N consecutive edges.
    s_now = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : 5'b0;
    s_hist.push_back(s_now);
    new_db = m_db;
    for (int b = 0; b < 5; b++) begin
      stable = (s_hist.size() >= DB_N);
      if (stable)
        for (int k = 1; k <= DB_N; k++)
          if (s_hist[s_hist.size()-k][b] == m_db[b]) stable = 1'b0;
      if (stable) new_db[b] = ~m_db[b];
    end
    m_db = new_db;
    pin_hist.push_back(cur_pins());
    while (pin_hist.size() > 8) void'(pin_hist.pop_front());
    while (s_hist.size() > 8) void'(s_hist.pop_front());
  endtask

  task automatic check_outputs();
    check("armed", armed, (m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM));
    check("exit_pending", exit_pending, (m_mode == M_EXIT));
    check("entry_pending", entry_pending, (m_mode == M_ENTRY));
    check("alarm_active", alarm_active, (m_mode == M_ALARM));
    check("zone_latched", zone_latched, m_zone);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return armed;
      1: return exit_pending;
      2: return entry_pending;
      default: return alarm_active;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int w, input logic v, input int bound, output int k);
    k = 0;
    while (sel(w) !== v && k < bound) begin
      step();
      k++;
    end
    check(tag, sel(w), v);
  endtask

  task automatic count_high(input int w, input int bound, output int n);
    n = 0;
    while (sel(w) === 1'b1 && n < bound) begin
      n++;
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check("reset_all", {armed, exit_pending, entry_pending, alarm_active, zone_latched}, 8'h00);
    rst_n = 1'b1;
    run(3);

    // Arming: exit delay length, motion during exit ignored.
    arm_in = 1'b1;
    wait_sig("exit_start", 1, 1'b1, 30, k);
    check("arm_latency", k, 8'd7);
    n = 0;
    while (exit_pending === 1'b1 && n < 60) begin
      n++;
      if (n == 1) motion_in = 1'b1;
      if (n == 7) motion_in = 1'b0;
      step();
    end
    check("exit_len", n, 8'd16);
    check("armed_after_exit", armed, 1'b1);
    check("no_alarm_after_exit", alarm_active, 1'b0);

    // Door glitch shorter than the debounce window, then a real door trip.
    run(10);
    door_in = 1'b1; run(3); door_in = 1'b0; run(10);
    check("glitch_no_entry", entry_pending, 1'b0);
    door_in = 1'b1;
    wait_sig("entry_start", 2, 1'b1, 30, k);
    check("door_latency", k, 8'd7);
    count_high(2, 100, n);
    check("entry_len", n, 8'd32);
    check("entry_timeout_alarm", alarm_active, 1'b1);
    check("entry_timeout_zone", zone_latched, 3'b001);
    door_in = 1'b0;
    run(10);

    // Manual reset from ALARM.
    reset_in = 1'b1; run(4); reset_in = 1'b0; run(8);
    check("reset_clears", {armed, alarm_active, zone_latched}, {1'b1, 1'b0, 3'b000});

    // Window during entry delay goes straight to ALARM.
    door_in = 1'b1; run(5); door_in = 1'b0;
    wait_sig("entry2_start", 2, 1'b1, 30, k);
    run(9);
    window_in = 1'b1;
    wait_sig("win_alarm", 3, 1'b1, 30, k);
    check("win_latency", k, 8'd7);
    check("win_zone", zone_latched, 3'b011);
    window_in = 1'b0;
    run(10);
    check("alarm_latched", alarm_active, 1'b1);

    // Disarm from ALARM.
    arm_in = 1'b0;
    run(8);
    check("disarm_all", {armed, exit_pending, entry_pending, alarm_active, zone_latched}, 8'h00);

    // Async reset mid entry delay.
    arm_in = 1'b1;
    wait_sig("rearm_exit", 1, 1'b1, 30, k);
    wait_sig("rearm_armed", 0, 1'b1, 40, k);
    door_in = 1'b1; run(5); door_in = 1'b0;
    wait_sig("entry3_start", 2, 1'b1, 30, k);
    run(5);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {armed, exit_pending, entry_pending, alarm_active, zone_latched}, 8'h00);
    model_reset();
    step();
    rst_n = 1'b1;

    // Clock enable low freezes everything mid entry delay.
    wait_sig("post_rst_exit", 1, 1'b1, 30, k);
    wait_sig("post_rst_armed", 0, 1'b1, 40, k);
    door_in = 1'b1; run(5); door_in = 1'b0;
    wait_sig("entry4_start", 2, 1'b1, 30, k);
    run(3);
    ena = 1'b0;
    for (int i = 0; i < 100; i++) begin
      {door_in, window_in, motion_in} = 3'($urandom);
      step();
    end
    check("frozen_entry", entry_pending, 1'b1);
    {door_in, window_in, motion_in} = 3'b000;
    ena = 1'b1;
    count_high(2, 100, n);
    check("frozen_entry_left", n, 8'd29);
    check("frozen_then_alarm", alarm_active, 1'b1);
    check("frozen_zone", zone_latched, 3'b001);

    // Randomized activity against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) arm_in = ~arm_in;
      if ($urandom_range(11) == 0) door_in = ~door_in;
      if ($urandom_range(15) == 0) window_in = ~window_in;
      if ($urandom_range(15) == 0) motion_in = ~motion_in;
      if ($urandom_range(39) == 0) reset_in = ~reset_in;
      if (!arm_in && $urandom_range(20) == 0) arm_in = 1'b1;
      ena = ($urandom_range(19) != 0);
      if ($urandom_range(999) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rnd_async_reset", {armed, exit_pending, entry_pending, alarm_active, zone_latched}, 8'h00);
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
